// File: rtl/pipeline_ctrl_unit.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use bubbles, branch flushes, memory freeze and watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch_equal,
  input  logic             exmem_zero,
  input  logic             exmem_mem_read,
  input  logic             exmem_mem_write,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic             mem_error,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  localparam int WD_RAW = $clog2(MEM_TIMEOUT + 1);
  localparam int WD_W   = (WD_RAW < 1) ? 1 : WD_RAW;
  localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  logic [1:0]      state_r, next_state_s;
  logic [WD_W-1:0] wd_cnt_r;
  logic            mem_error_r;
  logic            wd_clr_s, wd_inc_s, set_err_s;
  logic            taken_s, memop_s, luh_s;
  logic            mem_req_s, pc_write_s, pc_src_s, ifid_write_s;
  logic            ifid_flush_s, idex_flush_s, exmem_flush_s, pipe_hold_s;

  assign taken_s = exmem_branch_equal & exmem_zero;
  assign memop_s = exmem_mem_read | exmem_mem_write;
  assign luh_s   = idex_mem_read & (idex_rt != 5'd0) &
                   ((idex_rt == id_rs) | (idex_rt == id_rt));

  // Next-state and control decode from current state and hazard inputs.
  always_comb begin
    next_state_s  = state_r;
    wd_clr_s      = 1'b0;
    wd_inc_s      = 1'b0;
    set_err_s     = 1'b0;
    mem_req_s     = 1'b0;
    pc_write_s    = 1'b0;
    pc_src_s      = 1'b0;
    ifid_write_s  = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    pipe_hold_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        if (taken_s) begin
          pc_src_s      = 1'b1;
          ifid_flush_s  = 1'b1;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
        end else if (memop_s) begin
          mem_req_s = 1'b1;
          if (!mem_ready) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            pipe_hold_s  = 1'b1;
            next_state_s = ST_MEM_WAIT;
            wd_clr_s     = 1'b1;
          end else if (luh_s) begin
            // single-cycle access still lets the pending load-use bubble through
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
          end else begin
            next_state_s = ST_RUN;
          end
        end else if (luh_s) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          idex_flush_s = 1'b1;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
          next_state_s = ST_RUN;
        end else begin
          pipe_hold_s = 1'b1;
          wd_inc_s    = 1'b1;
          if ((MEM_TIMEOUT != 0) && (wd_cnt_r == WD_LAST)) begin
            next_state_s = ST_HALT;
            set_err_s    = 1'b1;
          end else begin
            next_state_s = ST_MEM_WAIT;
          end
        end
      end
      ST_HALT: begin
        pipe_hold_s = 1'b1;
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  // State, watchdog and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_RUN;
      wd_cnt_r    <= {WD_W{1'b0}};
      mem_error_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (wd_clr_s) begin
        wd_cnt_r <= {WD_W{1'b0}};
      end else if (wd_inc_s && (wd_cnt_r != WD_MAX)) begin
        wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      if (set_err_s) begin
        mem_error_r <= 1'b1;
      end else begin
        mem_error_r <= mem_error_r;
      end
    end
  end

  // Reset gates every control output so an abandoned access drops mem_req immediately.
  assign mem_req     = mem_req_s     & reset;
  assign pc_write    = pc_write_s    & reset;
  assign pc_src      = pc_src_s      & reset;
  assign ifid_write  = ifid_write_s  & reset;
  assign ifid_flush  = ifid_flush_s  & reset;
  assign idex_flush  = idex_flush_s  & reset;
  assign exmem_flush = exmem_flush_s & reset;
  assign pipe_hold   = pipe_hold_s   & reset;
  assign mem_error   = mem_error_r;
  assign state       = state_r;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             stall_ev_s, flush_ev_s;

  assign stall_ev_s = ((state_r == ST_RUN) || (state_r == ST_MEM_WAIT)) && !pc_write_s;
  assign flush_ev_s = (state_r == ST_RUN) && taken_s;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_ev_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_ev_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_count = stall_cnt_r;
  assign flush_count = flush_cnt_r;
`else
  assign stall_count = {CNT_W{1'b0}};
  assign flush_count = {CNT_W{1'b0}};
`endif

endmodule
